uart_loader: RTL and testbench

- Bus initiator that drives the 4-register ACIA-style UART register interface from the other side, in place of the 6502.
- Polls the status register, reads received bytes and parses a serial load protocol.
- Writes payload bytes into system RAM and returns ACK/NAK bytes through the transmit data register.
- Holds the CPU in reset until the host sends a Go command. Sits between the UART wrapper, the RAM write port and the CPU reset.

---
 rtl/uart_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// uart_loader: bus initiator that drives an ACIA-style 4-register UART in
// place of the CPU. It polls the UART status register, reads received bytes,
// parses a serial load protocol, writes payload bytes into system RAM and
// answers with ACK (0x06) / NAK (0x15) through the transmit data register.
// The CPU is held in reset until the host sends a Go ('G') command.
//
// Load frame: 'L' AH AL LEN DATA[LEN] CHK   (LEN 0 means 256 bytes)
//   CHK = (AH + AL + LEN + sum(DATA)) mod 256
// Go command: 'G' -> cpu_hold released, run pulses once, ACK sent.
//
// Build option: define UART_LOADER_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES clocks without a byte; the parser then returns to IDLE and
// sends NAK. Without the macro a partial frame waits indefinitely.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   uart_cs/we/addr    single-cycle register strobes (addr 0 data, 1 status)
//   uart_din           byte written to the UART data register
//   uart_dout          UART read data, valid the cycle after the strobe
//   mem_addr/wdata/we  RAM write port, one mem_we pulse per payload byte
//   cpu_hold           CPU reset request, 1 until Go is accepted
//   run                1-cycle pulse when Go is accepted
//   dbg_state          {parser state, bus sequencer state} for observation
//
// UART handshake: every access is a one-cycle uart_cs strobe. A read strobe
// presented in cycle N yields uart_dout in cycle N+1; because the strobes are
// registered, the sequencer waits one extra cycle (rd_wait) before sampling.
// Status bit1 = rx byte ready, bit0 = txbusy. A data read clears rx ready.
module uart_loader #(
  parameter int unsigned TX_GUARD       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        uart_cs,
  output logic        uart_we,
  output logic [1:0]  uart_addr,
  output logic [7:0]  uart_din,
  input  logic [7:0]  uart_dout,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        run,
  output logic [5:0]  dbg_state
);

  typedef enum logic [2:0] {
    RX_POLL, RX_CHK, RX_RD, RX_CAP, TX_POLL, TX_CHK, TX_WR, TX_WAIT
  } seq_t;

  typedef enum logic [2:0] {
    P_IDLE, P_AH, P_AL, P_LEN, P_DATA, P_CHK
  } parse_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [7:0] ACK         = 8'h06;
  localparam logic [7:0] NAK         = 8'h15;
  localparam int GW = (TX_GUARD > 1) ? $clog2(TX_GUARD) : 1;

  if (TX_GUARD < 1) begin : g_bad_guard
    $error("uart_loader: TX_GUARD must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_loader: TIMEOUT_CYCLES must be at least 2");
  end

  seq_t          seq;
  parse_t        prs;
  logic          rd_wait;   // read data not yet valid on uart_dout
  logic [7:0]    csum;
  logic [8:0]    count;     // remaining payload bytes, 1..256
  logic          tx_pend;   // one response byte waiting to be written
  logic [7:0]    tx_byte;
  logic [GW-1:0] guard_cnt;
  logic          byte_cap;  // uart_dout holds a received byte this cycle

  assign byte_cap  = (seq == RX_CAP) && !rd_wait;
  assign dbg_state = {prs, seq};

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      seq       <= RX_POLL;
      prs       <= P_IDLE;
      rd_wait   <= 1'b0;
      uart_cs   <= 1'b0;
      uart_we   <= 1'b0;
      uart_addr <= ADDR_STATUS;
      uart_din  <= 8'h00;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      cpu_hold  <= 1'b1;
      run       <= 1'b0;
      csum      <= 8'h00;
      count     <= 9'd0;
      tx_pend   <= 1'b0;
      tx_byte   <= 8'h00;
      guard_cnt <= '0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      uart_cs <= 1'b0;
      uart_we <= 1'b0;
      mem_we  <= 1'b0;
      run     <= 1'b0;

      // The address advances only after the write pulse has been seen.
      if (mem_we) mem_addr <= mem_addr + 16'd1;

      case (seq)
        RX_POLL: begin
          if (tx_pend) begin
            seq <= TX_POLL;
          end else begin
            uart_cs   <= 1'b1;
            uart_addr <= ADDR_STATUS;
            rd_wait   <= 1'b1;
            seq       <= RX_CHK;
          end
        end
        RX_CHK: begin
          if (rd_wait)           rd_wait <= 1'b0;
          else if (uart_dout[1]) seq     <= RX_RD;
          else                   seq     <= RX_POLL;
        end
        RX_RD: begin
          uart_cs   <= 1'b1;
          uart_addr <= ADDR_DATA;
          rd_wait   <= 1'b1;
          seq       <= RX_CAP;
        end
        RX_CAP: begin
          if (!byte_cap) begin
            rd_wait <= 1'b0;
          end else begin
            seq <= RX_POLL;
            case (prs)
              P_IDLE: begin
                if (uart_dout == 8'h4C) begin
                  csum <= 8'h00;
                  prs  <= P_AH;
                end else if (uart_dout == 8'h47) begin
                  cpu_hold <= 1'b0;
                  run      <= 1'b1;
                  tx_pend  <= 1'b1;
                  tx_byte  <= ACK;
                end
              end
              P_AH: begin
                mem_addr[15:8] <= uart_dout;
                csum           <= csum + uart_dout;
                prs            <= P_AL;
              end
              P_AL: begin
                mem_addr[7:0] <= uart_dout;
                csum          <= csum + uart_dout;
                prs           <= P_LEN;
              end
              P_LEN: begin
                count <= (uart_dout == 8'h00) ? 9'd256 : {1'b0, uart_dout};
                csum  <= csum + uart_dout;
                prs   <= P_DATA;
              end
              P_DATA: begin
                mem_wdata <= uart_dout;
                mem_we    <= 1'b1;
                csum      <= csum + uart_dout;
                count     <= count - 9'd1;
                if (count == 9'd1) prs <= P_CHK;
              end
              P_CHK: begin
                tx_pend <= 1'b1;
                tx_byte <= (uart_dout == csum) ? ACK : NAK;
                prs     <= P_IDLE;
              end
              default: prs <= P_IDLE;
            endcase
          end
        end
        TX_POLL: begin
          uart_cs   <= 1'b1;
          uart_addr <= ADDR_STATUS;
          rd_wait   <= 1'b1;
          seq       <= TX_CHK;
        end
        TX_CHK: begin
          if (rd_wait)            rd_wait <= 1'b0;
          else if (!uart_dout[0]) seq     <= TX_WR;
          else                    seq     <= TX_POLL;
        end
        TX_WR: begin
          uart_cs   <= 1'b1;
          uart_we   <= 1'b1;
          uart_addr <= ADDR_DATA;
          uart_din  <= tx_byte;
          tx_pend   <= 1'b0;
          guard_cnt <= '0;
          seq       <= TX_WAIT;
        end
        TX_WAIT: begin
          // The UART raises txbusy a few cycles after the load; polling
          // earlier would see a stale idle flag.
          if (guard_cnt == GW'(TX_GUARD - 1)) seq <= RX_POLL;
          else                                 guard_cnt <= guard_cnt + GW'(1);
        end
        default: seq <= RX_POLL;
      endcase

`ifdef UART_LOADER_TIMEOUT_EN
      // Only a busy parser can time out, and a busy parser never has a
      // response pending, so the NAK cannot collide with another response.
      if (byte_cap || prs == P_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_cnt <= '0;
        prs     <= P_IDLE;
        tx_pend <= 1'b1;
        tx_byte <= NAK;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Testbench for uart_loader: a behavioural UART register model feeds host
// bytes, frames are built at protocol level, and a negedge monitor checks
// every RAM write and UART transmit against scoreboard queues.
`timescale 1ns/1ps
module tb_uart_loader;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int unsigned TMO = 100;
`else
  localparam int unsigned TMO = 1200000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        uart_cs, uart_we, mem_we, cpu_hold, run;
  logic [1:0]  uart_addr;
  logic [7:0]  uart_din, uart_dout, mem_wdata;
  logic [15:0] mem_addr;
  logic [5:0]  dbg_state;

  uart_loader #(.TX_GUARD(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .uart_cs(uart_cs), .uart_we(uart_we), .uart_addr(uart_addr),
    .uart_din(uart_din), .uart_dout(uart_dout),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .run(run), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_mem_q[$];   // {addr, data}
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  host_q[$];      // bytes the host still has to send
  logic [7:0]  fdata[$];       // payload of the next frame
  int run_seen = 0;
  int exp_runs = 0;
  bit run_prev = 1'b0;
  bit force_busy = 1'b0;

  // ---------------- UART register model ----------------
  logic       rx_ready;
  logic [7:0] rx_data;
  logic [7:0] dout_r;
  int         busy_cnt;
  int         gap;
  int         status_reads = 0;
  wire        txbusy = force_busy || (busy_cnt != 0);
  assign uart_dout = dout_r;

  always @(posedge clk) begin
    if (rst) begin
      rx_ready <= 1'b0;
      rx_data  <= 8'h00;
      dout_r   <= 8'h00;
      busy_cnt <= 0;
      gap      <= 0;
    end else begin
      if (uart_cs && !uart_we) begin
        if (uart_addr == 2'd1) begin
          dout_r       <= {6'd0, rx_ready, txbusy};
          status_reads <= status_reads + 1;
        end else begin
          dout_r   <= rx_data;
          rx_ready <= 1'b0;
        end
      end
      if (uart_cs && uart_we) busy_cnt <= 12;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (!rx_ready) begin
        if (gap != 0) gap <= gap - 1;
        else if (host_q.size() != 0) begin
          rx_data  <= host_q.pop_front();
          rx_ready <= 1'b1;
          gap      <= $urandom_range(0, 6);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        checks++;
        if (exp_mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
        end else begin
          logic [23:0] e;
          e = exp_mem_q.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            errors++;
            $display("FAIL mem_write: got addr %h data %h, expected addr %h data %h",
                     mem_addr, mem_wdata, e[23:8], e[7:0]);
          end
        end
      end
      if (uart_cs && uart_we) begin
        checks++;
        if (force_busy || uart_addr !== 2'd0) begin
          errors++;
          $display("FAIL tx_write_cond: write with txbusy=%0b addr=%0d, expected txbusy=0 addr=0",
                   force_busy, uart_addr);
        end
        if (exp_tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_byte: got %h, expected no transmit", uart_din);
        end else begin
          logic [7:0] t;
          t = exp_tx_q.pop_front();
          if (uart_din !== t) begin
            errors++;
            $display("FAIL tx_byte: got %h, expected %h", uart_din, t);
          end
        end
      end
      if (run) begin
        run_seen++;
        checks++;
        if (run_prev) begin
          errors++;
          $display("FAIL run_width: got run high 2+ cycles, expected 1");
        end
      end
      run_prev = run;
    end else begin
      run_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_uart_cs"},   32'(uart_cs),   32'd0);
    check({tag, "_uart_we"},   32'(uart_we),   32'd0);
    check({tag, "_uart_addr"}, 32'(uart_addr), 32'd1);
    check({tag, "_uart_din"},  32'(uart_din),  32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_run"},       32'(run),       32'd0);
    check({tag, "_cpu_hold"},  32'(cpu_hold),  32'd1);
  endtask

  // Builds a load frame from fdata; the expected writes and response come
  // straight from the protocol rules.
  task automatic send_frame(input logic [15:0] a, input bit good);
    int len;
    int sum;
    logic [7:0] chk;
    len = fdata.size();
    sum = int'(a[15:8]) + int'(a[7:0]) + (len % 256);
    host_q.push_back(8'h4C);
    host_q.push_back(a[15:8]);
    host_q.push_back(a[7:0]);
    host_q.push_back(8'(len % 256));
    for (int i = 0; i < len; i++) begin
      host_q.push_back(fdata[i]);
      sum += int'(fdata[i]);
      exp_mem_q.push_back({a + 16'(i), fdata[i]});
    end
    chk = 8'(sum % 256);
    if (!good) chk = chk + 8'($urandom_range(1, 255));
    host_q.push_back(chk);
    exp_tx_q.push_back(good ? 8'h06 : 8'h15);
  endtask

  task automatic fill_random(input int len);
    fdata.delete();
    for (int i = 0; i < len; i++) fdata.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_go();
    host_q.push_back(8'h47);
    exp_tx_q.push_back(8'h06);
    exp_runs++;
  endtask

  task automatic send_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h4C || b == 8'h47) b = 8'h00;
      host_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((host_q.size() != 0 || rx_ready || exp_mem_q.size() != 0 || exp_tx_q.size() != 0)
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: got %0d writes and %0d responses outstanding, expected 0",
               name, exp_mem_q.size(), exp_tx_q.size());
      exp_mem_q.delete();
      exp_tx_q.delete();
    end
    repeat (60) @(posedge clk);
  endtask

  task automatic wait_consumed(input string name, input int budget);
    int n;
    n = 0;
    while ((host_q.size() != 0 || rx_ready || exp_mem_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_consume: got %0d host bytes unread, expected 0", name, host_q.size());
    end
    repeat (6) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Fixed frame, good checksum; CPU must stay held.
    fdata = '{8'h11, 8'h22, 8'h33};
    send_frame(16'h0200, 1'b1);
    wait_drain("frame_ack", 4000);
    check("cpu_hold_after_load", 32'(cpu_hold), 32'd1);

    // Same frame, wrong checksum: writes still happen, NAK returned.
    send_frame(16'h0200, 1'b0);
    wait_drain("frame_nak", 4000);

    // Bytes other than 'L'/'G' in IDLE are ignored.
    send_junk(5);
    wait_drain("junk", 4000);

    // Go command.
    send_go();
    wait_drain("go", 4000);
    check("cpu_hold_after_go", 32'(cpu_hold), 32'd0);
    check("run_count_after_go", 32'(run_seen), 32'(exp_runs));

    // Address wrap, loaded after Go.
    fdata = '{8'hAA, 8'hBB};
    send_frame(16'hFFFF, 1'b1);
    wait_drain("wrap", 4000);

    // LEN = 0 means 256 bytes.
    fill_random(256);
    send_frame(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    wait_drain("len256", 20000);

    // Random frames with junk between them.
    for (int f = 0; f < 6; f++) begin
      fill_random($urandom_range(1, 24));
      send_junk($urandom_range(0, 2));
      send_frame(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      wait_drain("random", 6000);
    end
    check("cpu_hold_stays_low", 32'(cpu_hold), 32'd0);

    // Response held while the transmitter reports busy.
    @(posedge clk); #1;
    force_busy = 1'b1;
    fill_random(3);
    send_frame(16'h4000, 1'b1);
    wait_consumed("busy", 4000);
    s0 = status_reads;
    repeat (50) @(posedge clk);
    check("busy_polls_continue", 32'(status_reads - s0 > 5), 32'd1);
    check("busy_ack_held", 32'(exp_tx_q.size()), 32'd1);
    #1;
    force_busy = 1'b0;
    wait_drain("busy", 4000);

    // Reset after AH: everything returns to reset values, no response.
    host_q.push_back(8'h4C);
    host_q.push_back(8'h5A);
    wait_consumed("midframe", 4000);
    check("midframe_addr_hi", 32'(mem_addr[15:8]), 32'h5A);
    @(posedge clk); #1;
    rst = 1'b1;
    host_q.delete();
    @(posedge clk); #1;
    check_reset("midframe_rst");
    rst = 1'b0;
    repeat (100) @(posedge clk);
    fill_random(4);
    send_frame(16'h0300, 1'b1);
    wait_drain("after_rst", 4000);
    check("cpu_hold_after_rst", 32'(cpu_hold), 32'd1);

`ifdef UART_LOADER_TIMEOUT_EN
    // Stalled frame is abandoned with NAK, then a normal frame works.
    host_q.push_back(8'h4C);
    host_q.push_back(8'h10);
    exp_tx_q.push_back(8'h15);
    wait_drain("timeout", 2000);
    fill_random(2);
    send_frame(16'h1000, 1'b1);
    wait_drain("after_timeout", 4000);
`endif

    check("run_count_final", 32'(run_seen), 32'(exp_runs));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #5ms;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
